// File: rtl/key_event_queue.sv
// Debounces 16 raw key levels, turns debounced edges into press/release events and
// queues them in a small first-word-fall-through FIFO for the page logic to pop.

module key_event_debounce #(
  parameter int STABLE_N = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic btn_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STABLE_N-1:0] hist_q, hist_d;
  logic                state_q, state_d;

  always_comb begin
    hist_d  = hist_q;
    state_d = state_q;
    if (tick_i) begin
      hist_d = {hist_q[STABLE_N-2:0], btn_i};
      if (&hist_d)       state_d = 1'b1;
      else if (~|hist_d) state_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q  <= '0;
      state_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = ~state_q & state_d;
  assign fall_o  = state_q & ~state_d;
endmodule

module key_event_queue #(
  parameter int SAMPLE_DIV = 50000,
  parameter int STABLE_N   = 4,
  parameter int FIFO_AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      btns,
  input  logic             rd_en,
  input  logic             clr_ovf,
  output logic             ev_valid,
  output logic [3:0]       ev_key,
  output logic             ev_press,
  output logic [15:0]      key_state,
  output logic [FIFO_AW:0] count,
  output logic             overflow
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef struct packed {
    logic [3:0] key;
    logic       press;
  } ev_t;

  logic [DIV_W-1:0]   div_q;
  logic               tick;
  logic [15:0]        state, rise, fall;
  logic [15:0]        pend_p_q, pend_p_d, pend_r_q, pend_r_d;
  logic [31:0]        pend_all, sel_mask;
  logic               sel_vld;
  logic [4:0]         sel_idx;
  ev_t                sel_ev;
  ev_t                mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q;
  logic               pop, push, drop;

  assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= tick ? '0 : div_q + 1'b1;
  end

  for (genvar k = 0; k < 16; k++) begin : g_lane
    key_event_debounce #(.STABLE_N(STABLE_N)) u_deb (
      .clk_i  (clk),
      .rst_i  (rst),
      .tick_i (tick),
      .btn_i  (btns[k]),
      .state_o(state[k]),
      .rise_o (rise[k]),
      .fall_o (fall[k])
    );
  end

  // Presses occupy indices 0..15 and releases 16..31, so the lowest set bit wins.
  assign pend_all = {pend_r_q, pend_p_q};

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (pend_all[i]) begin
        sel_vld = 1'b1;
        sel_idx = 5'(i);
      end
    end
  end

  assign sel_mask   = sel_vld ? (32'd1 << sel_idx) : 32'd0;
  assign sel_ev     = '{key: sel_idx[3:0], press: ~sel_idx[4]};
  // A fresh edge on the same edge as its clear must survive.
  assign pend_p_d   = (pend_p_q & ~sel_mask[15:0])  | rise;
  assign pend_r_d   = (pend_r_q & ~sel_mask[31:16]) | fall;

  assign pop  = rd_en && ev_valid;
  assign push = sel_vld && ((count_q < (FIFO_AW+1)'(DEPTH)) || pop);
  assign drop = sel_vld && !push;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_p_q <= '0;
      pend_r_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pend_p_q <= pend_p_d;
      pend_r_q <= pend_r_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  // Storage is masked by ev_valid on the way out, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sel_ev;
  end

  assign ev_valid  = (count_q != '0);
  assign ev_key    = ev_valid ? mem_q[rd_ptr_q].key   : 4'd0;
  assign ev_press  = ev_valid ? mem_q[rd_ptr_q].press : 1'b0;
  assign key_state = state;
  assign count     = count_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: tick-level vector table, hand sequences for the queue
// corner cases, and randomized traffic against a run-length/queue reference model.

module tb_key_event_queue;
  localparam int SD    = 32;
  localparam int SN    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, rd_en, clr_ovf;
  logic [15:0] btns;
  logic        ev_valid, ev_press, overflow;
  logic [3:0]  ev_key;
  logic [15:0] key_state;
  logic [AW:0] count;

  int checks   = 0;
  int failures = 0;

  key_event_queue #(.SAMPLE_DIV(SD), .STABLE_N(SN), .FIFO_AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .btns     (btns),
    .rd_en    (rd_en),
    .clr_ovf  (clr_ovf),
    .ev_valid (ev_valid),
    .ev_key   (ev_key),
    .ev_press (ev_press),
    .key_state(key_state),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] key;
    logic       press;
  } ev_t;

  // Reference model: each key tracks its latest sample value and how long it has run.
  ev_t         m_q[$];
  int          m_div;
  int          m_run  [16];
  logic        m_last [16];
  logic [15:0] m_state, m_pp, m_pr;
  logic        m_ovf;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_div = 0;
    for (int k = 0; k < 16; k++) begin
      m_last[k] = 1'b0;
      m_run[k]  = SN;
    end
    m_state = '0;
    m_pp    = '0;
    m_pr    = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step();
    bit   have = 0;
    bit   drop = 0;
    ev_t  sel  = '0;
    logic b;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 16; k++)
      if (!have && m_pp[k]) begin have = 1; sel.key = 4'(k); sel.press = 1'b1; m_pp[k] = 1'b0; end
    for (int k = 0; k < 16; k++)
      if (!have && m_pr[k]) begin have = 1; sel.key = 4'(k); sel.press = 1'b0; m_pr[k] = 1'b0; end
    if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
    if (have) begin
      if (m_q.size() < DEPTH) m_q.push_back(sel);
      else drop = 1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    if (m_div == SD - 1) begin
      for (int k = 0; k < 16; k++) begin
        b = btns[k];
        if (b == m_last[k]) begin
          if (m_run[k] < SN) m_run[k]++;
        end else begin
          m_last[k] = b;
          m_run[k]  = 1;
        end
        if (m_run[k] >= SN && m_state[k] != m_last[k]) begin
          if (m_last[k]) m_pp[k] = 1'b1;
          else           m_pr[k] = 1'b1;
          m_state[k] = m_last[k];
        end
      end
    end
    m_div = (m_div + 1) % SD;
  endtask

  task automatic check_model();
    ev_t h = (m_q.size() != 0) ? m_q[0] : '0;
    chk("m_ev_valid",  32'(ev_valid),  32'(m_q.size() != 0));
    chk("m_ev_key",    32'(ev_key),    32'(h.key));
    chk("m_ev_press",  32'(ev_press),  32'(h.press));
    chk("m_key_state", 32'(key_state), 32'(m_state));
    chk("m_count",     32'(count),     32'(m_q.size()));
    chk("m_overflow",  32'(overflow),  32'(m_ovf));
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic pop_expect(string name, int key, bit press);
    chk({name, "_valid"}, 32'(ev_valid), 32'd1);
    chk({name, "_key"},   32'(ev_key),   32'(key));
    chk({name, "_press"}, 32'(ev_press), 32'(press));
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic check_all_zero(string name);
    chk({name, "_valid"}, 32'(ev_valid),  32'd0);
    chk({name, "_key"},   32'(ev_key),    32'd0);
    chk({name, "_press"}, 32'(ev_press),  32'd0);
    chk({name, "_state"}, 32'(key_state), 32'd0);
    chk({name, "_count"}, 32'(count),     32'd0);
    chk({name, "_ovf"},   32'(overflow),  32'd0);
  endtask

  typedef struct {
    logic [15:0] btns;
    logic [15:0] exp_state;
    int          exp_count;
  } vec_t;

  vec_t vt[16];

  initial begin
    int n;
    vt[0]  = '{16'h0020, 16'h0000, 0};
    vt[1]  = '{16'h0020, 16'h0000, 0};
    vt[2]  = '{16'h0020, 16'h0000, 0};
    vt[3]  = '{16'h0020, 16'h0020, 1};
    vt[4]  = '{16'h0020, 16'h0020, 1};
    vt[5]  = '{16'h0000, 16'h0020, 1};
    vt[6]  = '{16'h0000, 16'h0020, 1};
    vt[7]  = '{16'h0000, 16'h0020, 1};
    vt[8]  = '{16'h0000, 16'h0000, 2};
    vt[9]  = '{16'h0004, 16'h0000, 2};
    vt[10] = '{16'h0000, 16'h0000, 2};
    vt[11] = '{16'h0004, 16'h0000, 2};
    vt[12] = '{16'h0004, 16'h0000, 2};
    vt[13] = '{16'h0000, 16'h0000, 2};
    vt[14] = '{16'h0004, 16'h0000, 2};
    vt[15] = '{16'h0000, 16'h0000, 2};

    rst = 1'b1; btns = '0; rd_en = 1'b0; clr_ovf = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Align so each tick lands mid-window, leaving time for the push.
    n = 0;
    while (m_div != 16 && n < 2 * SD) begin cyc(); n++; end
    chk("align", 32'(m_div), 32'd16);
    for (int i = 0; i < 16; i++) begin
      btns = vt[i].btns;
      repeat (SD) cyc();
      chk($sformatf("vec%0d_state", i), 32'(key_state), 32'(vt[i].exp_state));
      chk($sformatf("vec%0d_count", i), 32'(count),     32'(vt[i].exp_count));
    end
    pop_expect("t1_press", 5, 1'b1);
    pop_expect("t1_rel",   5, 1'b0);
    chk("t1_count", 32'(count), 32'd0);

    // Simultaneous presses: latency and index order.
    btns = 16'h0208;
    n = 0;
    while (!m_state[3] && n < 6 * SD) begin cyc(); n++; end
    chk("t3_rise",   32'(key_state), 32'h0208);
    chk("t3_lat0",   32'(ev_valid),  32'd0);
    cyc();
    chk("t3_lat1",   32'(ev_valid),  32'd1);
    chk("t3_key3",   32'(ev_key),    32'd3);
    chk("t3_press3", 32'(ev_press),  32'd1);
    rd_en = 1'b1;
    cyc();
    chk("t3_key9",   32'(ev_key),    32'd9);
    chk("t3_press9", 32'(ev_press),  32'd1);
    cyc();
    rd_en = 1'b0;
    chk("t3_count", 32'(count), 32'd0);

    // Overflow with ten presses and no pops.
    btns = 16'h0000;
    repeat (5 * SD) cyc();
    pop_expect("t4_rel3", 3, 1'b0);
    pop_expect("t4_rel9", 9, 1'b0);
    btns = 16'h03FF;
    repeat (5 * SD) cyc();
    chk("t4_count", 32'(count),    32'd8);
    chk("t4_ovf",   32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("t4_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) pop_expect($sformatf("t4_pop%0d", i), i, 1'b1);
    chk("t4_empty", 32'(count), 32'd0);

    // Full FIFO: a pop in the same cycle lets the selected event in.
    btns = 16'h0000;
    repeat (5 * SD) cyc();
    chk("t5_full", 32'(count), 32'd8);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    btns = 16'h1000;
    n = 0;
    while (!m_pp[12] && n < 6 * SD) begin cyc(); n++; end
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("t5_count", 32'(count),    32'd8);
    chk("t5_ovf",   32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++) pop_expect($sformatf("t5_rel%0d", i), i, 1'b0);
    pop_expect("t5_tail", 12, 1'b1);
    chk("t5_empty", 32'(count), 32'd0);

    // Reset mid-queue with events still pending.
    btns = 16'h101F;
    repeat (5 * SD) cyc();
    chk("t6_count", 32'(count), 32'd5);
    btns = 16'hFC1F;
    n = 0;
    while (m_pp == '0 && n < 6 * SD) begin cyc(); n++; end
    chk("t6_pend", 32'(m_pp != '0), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    model_reset();
    cyc();
    rst = 1'b0;
    repeat (3 * SD) cyc();
    chk("t6_3ticks", 32'(key_state), 32'h0000);
    repeat (SD) cyc();
    chk("t6_4ticks", 32'(key_state), 32'hFC1F);
    repeat (SD) cyc();

    // Randomized traffic, including bounces, pops, clears and the odd reset.
    for (int i = 0; i < 5000; i++) begin
      int k;
      if ($urandom_range(0, 39) == 0) begin
        k = $urandom_range(0, 15);
        btns[k] = ~btns[k];
      end
      rd_en   = ($urandom_range(0, 5) == 0);
      clr_ovf = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 1999) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        cyc();
        rst = 1'b0;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
